// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one synchronous write port, x0 tied to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 5,
  parameter int A0_INDEX  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] AD1,
  input  logic [ADDR_SIZE-1:0] AD2,
  input  logic [ADDR_SIZE-1:0] AD3,
  input  logic                 WE3,
  input  logic [DATA_SIZE-1:0] WD3,
  output logic [DATA_SIZE-1:0] RD1,
  output logic [DATA_SIZE-1:0] RD2,
  output logic [DATA_SIZE-1:0] a0
);

  localparam int                 DEPTH   = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] A0_ADDR = ADDR_SIZE'(A0_INDEX);

  logic [DATA_SIZE-1:0] regs_r [DEPTH];
  logic                 wr_en_s;
  logic [DATA_SIZE-1:0] rd1_s;
  logic [DATA_SIZE-1:0] rd2_s;
  logic [DATA_SIZE-1:0] a0_s;

  // Writes to x0 are dropped here, so entry 0 holds its reset value of zero forever.
  assign wr_en_s = WE3 && (AD3 != {ADDR_SIZE{1'b0}});

  // Storage: asynchronous clear, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_SIZE{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[AD3] <= WD3;
    end
  end

  // Read ports and a0 mirror, with optional forwarding of the in-flight write.
  always_comb begin
    rd1_s = regs_r[AD1];
    rd2_s = regs_r[AD2];
    a0_s  = regs_r[A0_ADDR];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rst_n so outputs stay zero throughout reset.
    if (rst_n && wr_en_s && (AD1 == AD3)) begin
      rd1_s = WD3;
    end else begin
      rd1_s = regs_r[AD1];
    end
    if (rst_n && wr_en_s && (AD2 == AD3)) begin
      rd2_s = WD3;
    end else begin
      rd2_s = regs_r[AD2];
    end
    if (rst_n && wr_en_s && (AD3 == A0_ADDR)) begin
      a0_s = WD3;
    end else begin
      a0_s = regs_r[A0_ADDR];
    end
`endif
  end

  assign RD1 = rd1_s;
  assign RD2 = rd2_s;
  assign a0  = a0_s;

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file that drives the ALU operand inputs (ALUop1/ALUop2) and receives the ALU result as write-back data.
- Sits between decode and the ALU in the single-cycle datapath.
- Two combinational read ports, one synchronous write port.
- Register x0 is hardwired to zero.
- A dedicated a0 (x10) output is provided for top-level observation.

Parameters:
- DATA_SIZE, 32, register width in bits; must match the ALU DATA_SIZE.
- ADDR_SIZE, 5, register address width; the file holds 2**ADDR_SIZE entries.
- A0_INDEX, 10, index of the register mirrored on port a0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- AD1  in  ADDR_SIZE  read address, port 1 (rs1).
- AD2  in  ADDR_SIZE  read address, port 2 (rs2).
- AD3  in  ADDR_SIZE  write address (rd).
- WE3  in  1  write enable.
- WD3  in  DATA_SIZE  write data (ALUout or immediate/PC write-back).
- RD1  out  DATA_SIZE  read data 1, feeds ALUop1.
- RD2  out  DATA_SIZE  read data 2, feeds ALUop2 mux.
- a0  out  DATA_SIZE  continuous copy of register A0_INDEX.

Behaviour:
- Storage: 2**ADDR_SIZE x DATA_SIZE flops; no RAM inference is required.
- Reset:
  - rst_n low immediately, asynchronously, clears every entry to 0.
  - Therefore RD1 = RD2 = a0 = 0 while in reset (with any addresses).
  - Reset deassertion is synchronised upstream; this block takes no action on deassertion.
- Write:
  - On rising clk with rst_n high, WE3 = 1 and AD3 != 0, the entry at AD3 <= WD3.
  - WE3 = 0 means no state change.
- x0:
  - A write with AD3 = 0 is discarded.
  - Reads of address 0 always return 0, regardless of any prior write attempt.
- Read:
  - RD1 = reg[AD1] and RD2 = reg[AD2], purely combinational; zero-cycle latency from an address change.
  - AD1 = AD2 is legal; both ports return the same value.
- Write latency: data written at edge N is visible on RD1/RD2/a0 immediately after edge N (same-cycle read-during-write returns the OLD value unless the optional feature is enabled).
- a0 = reg[A0_INDEX], combinational from storage; it changes only after a committed write to A0_INDEX or on reset.
- Reset mid-operation:
  - If rst_n is low at a clk edge with WE3 = 1, the write is lost.
  - All entries read 0 after reset, including the target address.
- Addresses are full-range decoded. There is no out-of-range case, because the depth is exactly 2**ADDR_SIZE.
- No X propagation: all outputs are defined after the first reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When WE3 = 1, AD3 != 0 and AD1 == AD3, RD1 = WD3 combinationally in the same cycle; likewise RD2 when AD2 == AD3.
  - a0 likewise shows WD3 when AD3 == A0_INDEX and WE3 = 1.
  - Bypass never applies to AD3 = 0.
  - Bypass is suppressed while rst_n is low (outputs stay 0).
- Undefined: no bypass; a read-during-write returns the stored (old) value until after the edge.

Test Plan:
1. Reset flush: write x5 = 0xDEADBEEF, then pulse rst_n low mid-cycle (not at an edge) -> RD1 (AD1 = 5) goes to 0 asynchronously before the next edge; a0 = 0.
2. Basic write/read: WE3 = 1, AD3 = 3, WD3 = 0x0000_00FF, one edge; then AD1 = 3, AD2 = 3 -> RD1 = RD2 = 0x0000_00FF. Then WE3 = 0, WD3 = 0x1234, one edge -> still 0xFF.
3. x0 immunity: WE3 = 1, AD3 = 0, WD3 = 0xFFFF_FFFF, one edge; AD1 = 0 -> RD1 = 0. With REGFILE_BYPASS_EN also check RD1 = 0 during the write cycle.
4. a0 mirror: WE3 = 1, AD3 = 10, WD3 = 0x0000_002A, one edge -> a0 = 0x2A. Then AD3 = 11, WD3 = 7, one edge -> a0 remains 0x2A.
5. Read-during-write: x4 = 1 preloaded; same cycle AD1 = 4, AD3 = 4, WE3 = 1, WD3 = 9.
   - Without macro: RD1 = 1 before the edge, 9 after.
   - With macro: RD1 = 9 before the edge.
6. Write during reset: hold rst_n = 0 across an edge with WE3 = 1, AD3 = 2, WD3 = 0x55; release; AD1 = 2 -> RD1 = 0.
